cnu_minsum_serial: RTL and testbench
====================================

# cnu_minsum_serial

Serial offset-min-sum check node unit (CNU) for the DG-LDPC decoder. It consumes variable-to-check messages produced by the shuffled VNU one edge per cycle. It saturates them to the 6-bit message format the VNU expects and computes the check node's min1/min2/sign state. It then streams back one 6-bit check-to-variable message per edge, which feeds the VNU's message inputs on the next iteration.

## Interface
Parameters:
- DC, 6: check node degree (edges per frame); 2..16.
- IW, 10: input message width, signed two's complement (VNU output width).
- OW, 6: output message width, signed two's complement (VNU input width).
- OFFSET, 1: offset subtracted from output magnitudes; 0..(2^(OW-1)-1).

Ports:
- clk, in, 1: clock; all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- i_valid, in, 1: input message valid.
- o_ready, out, 1: block accepts input; high only in COLLECT.
- i_data, in, IW: variable-to-check message.
- o_valid, out, 1: output message valid; high only in EMIT.
- i_ready, in, 1: downstream accepts output.
- o_data, out, OW: check-to-variable message for edge o_idx.
- o_idx, out, $clog2(DC): edge index of o_data (0..DC-1).
- o_last, out, 1: high with o_valid on edge DC-1.
- o_parity, out, 1: XOR of all input sign bits of the last completed frame (syndrome bit).
- o_parity_valid, out, 1: one-cycle pulse when o_parity updates.

## Operation
- There are two states: COLLECT and EMIT. Reset enters COLLECT with the edge counter at 0, min1 = min2 = 2^(OW-1)-1 (31), idx = 0, and parity = 0.
- Input accept happens when i_valid && o_ready.
- Saturation: i_data is clamped to [-(2^(OW-1)-1), +(2^(OW-1)-1)], i.e. [-31, +31]. The value -32 is never produced.
- Each edge k stores sign_k = MSB of i_data (zero counts as positive) and mag_k = |saturated value|. Storage is a DC-entry register buffer.
- Min tracking on each accept:
  - if mag < min1: min2 = min1, min1 = mag, idx = k;
  - else if mag < min2: min2 = mag.
  - Ties keep the earliest index.
  - parity ^= sign_k.
- COLLECT to EMIT happens on the accept of edge DC-1. That accept's contribution is included in min1/min2/idx/parity.
- EMIT output for edge k:
  - mag = (k == idx) ? min2 : min1;
  - mag = max(mag - OFFSET, 0);
  - sign = parity ^ sign_k;
  - o_data = sign ? -mag : +mag. A zero magnitude outputs 0 regardless of sign.
- An output handshake is o_valid && i_ready; the emit counter advances only on a handshake.
- EMIT to COLLECT happens on the handshake of edge DC-1. At that point min1/min2 return to 31, idx and parity clear, and the counter returns to 0.
- o_parity latches the frame parity on entry to EMIT. o_parity_valid pulses for that cycle.
- Frames never overlap; COLLECT and EMIT are mutually exclusive.

## Timing
- Reset values: o_ready = 0 while rst is high, and 1 in the first cycle after rst deasserts. o_valid, o_data, o_idx, o_last, o_parity and o_parity_valid are all 0.
- o_data, o_idx and o_last are driven from registered state (no combinational path from i_data). o_ready and o_valid are pure state decodes.
- Latency: o_valid rises in the cycle after the accept of edge DC-1. o_ready rises in the cycle after the handshake of edge DC-1.
- Minimum frame time is 2*DC cycles, with no stall cycles beyond backpressure.
- i_valid gaps in COLLECT only stall the counter. i_ready low in EMIT holds o_data, o_idx and o_last stable.
- If rst is asserted mid-COLLECT or mid-EMIT, the frame is discarded and outputs take their reset values in the next cycle. No partial frame is ever emitted.
- i_valid asserted during EMIT is ignored, because o_ready = 0 means the data is not consumed.

## Test plan
- Basic frame (DC=6, OFFSET=1): input 5, -3, 8, 2, -7, 4 -> outputs 1, -1, 1, 2, -1, 1 on o_idx 0..5; o_last on edge 5; o_parity = 0.
- Saturation: input 400, -512, 31, -32, 100, -100 -> all magnitudes are 31, so min1 = min2 = 31 and idx = 0. Outputs are ±30 with sign = parity ^ sign_k: -30, 30, -30, 30, -30, 30. o_parity = 1.
- Tie and parity: input -6, 6, 6, 10, 10, 10 -> min1 = min2 = 6 with idx 0; outputs 5, -5, -5, -5, -5, -5; o_parity = 1.
- Zero and offset clamp: all-zero input -> six outputs of 0; o_parity = 0. A frame with a magnitude of 1 and OFFSET=1 yields 0 on the non-min edges.
- Backpressure and bubbles: randomly toggle i_valid and i_ready across 3 back-to-back frames. Outputs must match the scoreboard, and o_data must stay stable while i_ready is low. o_ready must be 0 throughout EMIT.
- Reset mid-operation: assert rst after 3 inputs, then after 2 outputs -> o_valid drops the next cycle, and the following full frame produces correct results unaffected by the aborted data.

Source files
------------

// File: rtl/cnu_minsum_serial.sv
// Serial offset-min-sum check node: collects DC variable-to-check messages one per cycle,
// then streams DC check-to-variable messages back with valid/ready flow control.
module cnu_minsum_serial #(
   parameter int DC     = 6,
   parameter int IW     = 10,
   parameter int OW     = 6,
   parameter int OFFSET = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [IW-1:0]         i_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [OW-1:0]         o_data,
   output logic [$clog2(DC)-1:0] o_idx,
   output logic                  o_last,
   output logic                  o_parity,
   output logic                  o_parity_valid
);
   localparam int CW = $clog2(DC);
   localparam int MW = OW - 1;
   localparam logic [MW-1:0] MAXM = '1;
   localparam logic [MW-1:0] OFFS = MW'(OFFSET);
   localparam logic [CW-1:0] LAST = CW'(DC - 1);

   typedef enum logic {S_COLLECT, S_EMIT} state_e;

   state_e        state_q;
   logic          run_q;
   logic [CW-1:0] cnt_q;
   logic [MW-1:0] min1_q, min2_q;
   logic [CW-1:0] idx_q;
   logic          par_q;
   logic [DC-1:0] sgn_q;
   logic          par_out_q, par_vld_q;

   logic [IW:0]   abs_w;
   logic [MW-1:0] mag_w, base_w, omag_w;
   logic          sgn_w, osgn_w, acc_w, hs_w;

   // Saturate to +/-(2^(OW-1)-1) by clamping the magnitude; -2^(OW-1) can never appear.
   always_comb begin
      sgn_w  = i_data[IW-1];
      abs_w  = sgn_w ? (~{1'b1, i_data} + (IW+1)'(1)) : {1'b0, i_data};
      mag_w  = (abs_w > (IW+1)'(MAXM)) ? MAXM : abs_w[MW-1:0];
      base_w = (cnt_q == idx_q) ? min2_q : min1_q;
      omag_w = (base_w > OFFS) ? (base_w - OFFS) : '0;
      osgn_w = par_q ^ sgn_q[cnt_q];
   end

   assign o_ready        = run_q && (state_q == S_COLLECT);
   assign o_valid        = (state_q == S_EMIT);
   assign o_data         = o_valid ? (osgn_w ? -{1'b0, omag_w} : {1'b0, omag_w}) : '0;
   assign o_idx          = o_valid ? cnt_q : '0;
   assign o_last         = o_valid && (cnt_q == LAST);
   assign o_parity       = par_out_q;
   assign o_parity_valid = par_vld_q;
   assign acc_w          = i_valid && o_ready;
   assign hs_w           = o_valid && i_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_COLLECT;
         run_q     <= 1'b0;
         cnt_q     <= '0;
         min1_q    <= MAXM;
         min2_q    <= MAXM;
         idx_q     <= '0;
         par_q     <= 1'b0;
         par_out_q <= 1'b0;
         par_vld_q <= 1'b0;
      end else begin
         run_q     <= 1'b1;
         par_vld_q <= 1'b0;
         case (state_q)
            S_COLLECT: if (acc_w) begin
               par_q <= par_q ^ sgn_w;
               if (mag_w < min1_q) begin
                  min2_q <= min1_q;
                  min1_q <= mag_w;
                  idx_q  <= cnt_q;
               end else if (mag_w < min2_q) begin
                  min2_q <= mag_w;
               end
               if (cnt_q == LAST) begin
                  cnt_q     <= '0;
                  state_q   <= S_EMIT;
                  par_out_q <= par_q ^ sgn_w;
                  par_vld_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_EMIT: if (hs_w) begin
               if (cnt_q == LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_COLLECT;
                  min1_q  <= MAXM;
                  min2_q  <= MAXM;
                  idx_q   <= '0;
                  par_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= S_COLLECT;
         endcase
      end
   end

   // Only signs are buffered; magnitudes are fully summarised by min1/min2/idx.
   always_ff @(posedge clk) begin
      if (acc_w) sgn_q[cnt_q] <= sgn_w;
   end
endmodule

// File: tb/tb_cnu_minsum_serial.sv
// Directed and randomized bench for cnu_minsum_serial against a frame-level min-sum model.
module tb_cnu_minsum_serial;
   localparam int DC = 6, IW = 10, OW = 6, OFFSET = 1;
   localparam int CW = $clog2(DC);

   logic clk = 1'b0;
   logic rst, i_valid, o_ready, o_valid, i_ready, o_last, o_parity, o_parity_valid;
   logic [IW-1:0] i_data;
   logic [OW-1:0] o_data;
   logic [CW-1:0] o_idx;

   int n_asrt = 0, n_fail = 0;
   int fin[DC];
   int exp_d[DC];
   int exp_par;

   always #5 clk = ~clk;

   cnu_minsum_serial #(.DC(DC), .IW(IW), .OW(OW), .OFFSET(OFFSET)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_idx(o_idx),
      .o_last(o_last), .o_parity(o_parity), .o_parity_valid(o_parity_valid)
   );

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      n_asrt++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Frame-level reference: saturate, pick the earliest minimum, second minimum over the rest.
   function automatic void model();
      int m[DC];
      int s[DC];
      int v, idx, mn2, par, b;
      par = 0;
      for (int k = 0; k < DC; k++) begin
         v = fin[k];
         if (v > 31) v = 31;
         if (v < -31) v = -31;
         m[k] = (v < 0) ? -v : v;
         s[k] = (fin[k] < 0) ? 1 : 0;
         par ^= s[k];
      end
      idx = 0;
      for (int k = 0; k < DC; k++) if (m[k] < m[idx]) idx = k;
      mn2 = 31;
      for (int k = 0; k < DC; k++) if (k != idx && m[k] < mn2) mn2 = m[k];
      for (int k = 0; k < DC; k++) begin
         b = (k == idx) ? mn2 : m[idx];
         b = b - OFFSET;
         if (b < 0) b = 0;
         exp_d[k] = (par ^ s[k]) ? -b : b;
      end
      exp_par = par;
   endfunction

   task automatic send(input int n, input bit bub);
      int k = 0, cyc = 0;
      while (k < n && cyc < 500) begin
         @(negedge clk);
         cyc++;
         i_valid = bub ? 1'($urandom_range(0, 1)) : 1'b1;
         i_data  = IW'(fin[k]);
         if (i_valid && o_ready) k++;
      end
      check("send_count", k, n);
   endtask

   task automatic recv(input int n, input bit bp);
      int j = 0, cyc = 0;
      bit hold = 1'b0;
      logic [OW-1:0] pd;
      logic [CW-1:0] pi;
      while (j < n && cyc < 500) begin
         check("o_ready_in_emit", o_ready, 0);
         check("o_valid_in_emit", o_valid, 1);
         if (hold) begin
            check("hold_data", o_data, pd);
            check("hold_idx", o_idx, pi);
         end
         i_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (i_ready) begin
            check($sformatf("o_data[%0d]", j), $signed(o_data), exp_d[j]);
            check("o_idx", o_idx, j);
            check("o_last", o_last, (j == DC - 1) ? 1 : 0);
            j++;
            hold = 1'b0;
         end else begin
            hold = 1'b1;
            pd   = o_data;
            pi   = o_idx;
         end
         @(negedge clk);
         cyc++;
      end
      check("recv_count", j, n);
      i_ready = 1'b0;
   endtask

   task automatic run_frame(input bit bub, input bit bp, input bit use_model);
      if (use_model) model();
      send(DC, bub);
      @(negedge clk);
      i_valid = 1'b1;              // held high through EMIT; must be ignored
      i_data  = IW'($urandom);
      check("o_valid_latency", o_valid, 1);
      check("o_parity_valid", o_parity_valid, 1);
      check("o_parity", o_parity, exp_par);
      recv(DC, bp);
      i_valid = 1'b0;
      check("o_ready_after_frame", o_ready, 1);
      check("o_valid_after_frame", o_valid, 0);
   endtask

   task automatic rand_fill();
      for (int k = 0; k < DC; k++)
         fin[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) - 512
                                              : int'($urandom_range(0, 80)) - 40;
   endtask

   initial begin
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
      repeat (3) @(negedge clk);
      check("rst_o_ready", o_ready, 0);
      check("rst_o_valid", o_valid, 0);
      check("rst_o_data", o_data, 0);
      check("rst_o_idx", o_idx, 0);
      check("rst_o_last", o_last, 0);
      check("rst_o_parity", o_parity, 0);
      check("rst_o_parity_valid", o_parity_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      check("o_ready_after_rst", o_ready, 1);

      fin = '{5, -3, 8, 2, -7, 4};        exp_d = '{1, -1, 1, 2, -1, 1};         exp_par = 0;
      run_frame(0, 0, 0);
      fin = '{400, -512, 31, -32, 100, -100}; exp_d = '{-30, 30, -30, 30, -30, 30}; exp_par = 1;
      run_frame(0, 0, 0);
      fin = '{-6, 6, 6, 10, 10, 10};      exp_d = '{5, -5, -5, -5, -5, -5};      exp_par = 1;
      run_frame(0, 0, 0);
      fin = '{0, 0, 0, 0, 0, 0};          exp_d = '{0, 0, 0, 0, 0, 0};           exp_par = 0;
      run_frame(0, 0, 0);
      fin = '{1, -4, 7, 3, -9, 12};       exp_d = '{2, 0, 0, 0, 0, 0};           exp_par = 0;
      run_frame(0, 0, 0);

      for (int f = 0; f < 3; f++) begin
         rand_fill();
         run_frame(1, 1, 1);
      end

      // Abort mid-COLLECT
      rand_fill();
      send(3, 0);
      @(negedge clk);
      i_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("abort_c_o_ready", o_ready, 0);
      check("abort_c_o_valid", o_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      check("abort_c_ready_back", o_ready, 1);

      // Abort mid-EMIT
      rand_fill();
      model();
      send(DC, 0);
      @(negedge clk);
      i_valid = 1'b0;
      check("abort_e_o_valid_up", o_valid, 1);
      recv(2, 0);
      rst = 1'b1;
      @(negedge clk);
      check("abort_e_o_valid", o_valid, 0);
      check("abort_e_o_data", o_data, 0);
      check("abort_e_o_idx", o_idx, 0);
      check("abort_e_o_last", o_last, 0);
      check("abort_e_o_parity", o_parity, 0);
      check("abort_e_o_parity_valid", o_parity_valid, 0);
      check("abort_e_o_ready", o_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      check("abort_e_ready_back", o_ready, 1);

      for (int f = 0; f < 3; f++) begin
         rand_fill();
         run_frame(f[0], 1, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
